vga_arbiter: RTL and testbench

VGA_ARBITER -- requirements
Module: vga_arbiter

---
 rtl/vga_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/vga_arbiter.sv | 133 +++++++++++++
 tb/tb_vga_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Purpose: shared FSM state type and default geometry constants for the VGA arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    // Default pixel geometry: 256x128 display with 3-bit colour.
    localparam int X_W_DEF = 8;
    localparam int Y_W_DEF = 7;
    localparam int C_W_DEF = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLOT = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // The round-robin pointer is kept at least one bit wide, so a
    // single-channel build still has a legal vector.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin winner select starting the search at ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether to act on the grant.
//
// Ports:
//   req   - per-channel request vector
//   ptr   - channel index the search starts at (wraps modulo NUM_CH)
//   grant - one-hot winner
//   idx   - binary index of the winner (0 when any is low)
//   any   - at least one request is set
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  idx,
    output logic              any
);

    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Walk the channels in priority order ptr, ptr+1, ... and keep the
        // first hit; later hits are ignored once any is set.
        for (int i = 0; i < NUM_CH; i++) begin
            c = (int'(ptr) + i) % NUM_CH;
            if (!any && req[c]) begin
                grant[c] = 1'b1;
                idx      = PTR_W'(c);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_arbiter.sv
// Purpose: round-robin arbiter serialising per-channel pixel requests onto one VGA plotter.
// Latency: request sampled with busy low at edge N -> plot/ack in cycle N+1; at most one plot per 3 cycles.
// Backpressure: busy high holds off new grants; a plot already issued always completes.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   busy                - plotter busy, blocks new grants
//   req                 - per-channel request, held by the requester until acked
//   x_in/y_in/color_in  - packed per-channel pixel, channel i at [i*W +: W]
//   ack                 - one-hot, one-cycle grant pulse to the served channel
//   x_out/y_out/color_out - registered pixel presented to the plotter
//   plot                - one-cycle write strobe to the plotter
//   plot_count          - running plot total, only when VGA_ARB_COUNT_EN is defined
module vga_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int X_W    = X_W_DEF,
    parameter int Y_W    = Y_W_DEF,
    parameter int C_W    = C_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  busy,
    input  logic [NUM_CH-1:0]     req,
    input  logic [NUM_CH*X_W-1:0] x_in,
    input  logic [NUM_CH*Y_W-1:0] y_in,
    input  logic [NUM_CH*C_W-1:0] color_in,
    output logic [NUM_CH-1:0]     ack,
    output logic [X_W-1:0]        x_out,
    output logic [Y_W-1:0]        y_out,
    output logic [C_W-1:0]        color_out,
    output logic                  plot
`ifdef VGA_ARB_COUNT_EN
    ,
    output logic [15:0]           plot_count
`endif
);

    localparam int PTR_W = ptr_width(NUM_CH);

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    ptr;
    logic [NUM_CH-1:0]   win_grant;
    logic [PTR_W-1:0]    win_idx;
    logic                win_any;
    logic [NUM_CH-1:0]   win_q;
    logic                load;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // plot and ack decode straight from the state register so that reset,
    // which clears state asynchronously, also clears them asynchronously.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        plot      = 1'b0;
        ack       = '0;
        case (state)
            S_IDLE: begin
                if (win_any && !busy) begin
                    load      = 1'b1;
                    state_nxt = S_PLOT;
                end
            end
            S_PLOT: begin
                plot      = 1'b1;
                ack       = win_q;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Pixel, winner and pointer only move on a grant; otherwise they hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            win_q     <= '0;
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
        end else if (load) begin
            win_q     <= win_grant;
            x_out     <= x_in[win_idx*X_W +: X_W];
            y_out     <= y_in[win_idx*Y_W +: Y_W];
            color_out <= color_in[win_idx*C_W +: C_W];
            if (NUM_CH == 1) begin
                ptr <= '0;
            end else if (win_idx == PTR_W'(NUM_CH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= win_idx + 1'b1;
            end
        end
    end

`ifdef VGA_ARB_COUNT_EN
    // Free-running 16-bit total, wraps naturally at 0xFFFF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plot_count <= '0;
        end else if (state == S_PLOT) begin
            plot_count <= plot_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_arbiter.sv
// Purpose: self-checking bench for vga_arbiter (NUM_CH=4, 8/7/3-bit pixel).
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_arbiter;

    localparam int NCH = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                busy;
    logic [NCH-1:0]      req;
    logic [NCH*8-1:0]    x_in;
    logic [NCH*7-1:0]    y_in;
    logic [NCH*3-1:0]    color_in;
    logic [NCH-1:0]      ack;
    logic [7:0]          x_out;
    logic [6:0]          y_out;
    logic [2:0]          color_out;
    logic                plot;
`ifdef VGA_ARB_COUNT_EN
    logic [15:0]         plot_count;
`endif

    vga_arbiter #(
        .NUM_CH (NCH),
        .X_W    (8),
        .Y_W    (7),
        .C_W    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .busy       (busy),
        .req        (req),
        .x_in       (x_in),
        .y_in       (y_in),
        .color_in   (color_in),
        .ack        (ack),
        .x_out      (x_out),
        .y_out      (y_out),
        .color_out  (color_out),
        .plot       (plot)
`ifdef VGA_ARB_COUNT_EN
        ,
        .plot_count (plot_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: transaction-level view of the arbiter.
    //   m_ptr   - channel the next round-robin search starts at
    //   m_cool  - a plot has happened and no busy-low edge has been seen since
    //   e_*     - what the outputs must show in the cycle after the next edge
    int          m_ptr;
    bit          m_cool;
    logic        e_plot;
    logic [3:0]  e_ack;
    logic [7:0]  e_x;
    logic [6:0]  e_y;
    logic [2:0]  e_c;
    int          e_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (r[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_ptr  = 0;
        m_cool = 1'b0;
        e_plot = 1'b0;
        e_ack  = '0;
        e_x    = '0;
        e_y    = '0;
        e_c    = '0;
        e_cnt  = 0;
    endtask

    // Predict the effect of the coming rising edge from the inputs now applied.
    task automatic model_edge();
        int w;
        if (reset) begin
            model_clear();
            return;
        end
        if (e_plot) begin
            // Plot cycle ends: strobe drops, a busy-low edge is needed before the next grant.
            e_plot = 1'b0;
            e_ack  = '0;
            m_cool = 1'b1;
            e_cnt  = (e_cnt + 1) % 65536;
        end else if (m_cool) begin
            if (!busy) m_cool = 1'b0;
        end else begin
            w = rr_pick(req, m_ptr);
            if (w >= 0 && !busy) begin
                e_plot = 1'b1;
                e_ack  = 4'(1 << w);
                e_x    = x_in[w*8 +: 8];
                e_y    = y_in[w*7 +: 7];
                e_c    = color_in[w*3 +: 3];
                m_ptr  = (w + 1) % NCH;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".plot"},  32'(plot),      32'(e_plot));
        chk({tag, ".ack"},   32'(ack),       32'(e_ack));
        chk({tag, ".x"},     32'(x_out),     32'(e_x));
        chk({tag, ".y"},     32'(y_out),     32'(e_y));
        chk({tag, ".color"}, 32'(color_out), 32'(e_c));
`ifdef VGA_ARB_COUNT_EN
        chk({tag, ".count"}, 32'(plot_count), 32'(e_cnt));
`endif
    endtask

    // Inputs are driven while clk is low; one tick = model the edge, take it,
    // then compare at the following falling edge.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    int       plot_at[$];
    logic [3:0] ack_seq[$];
    logic [3:0] exp_seq [5];

    initial begin
        reset    = 1'b1;
        busy     = 1'b0;
        req      = '0;
        x_in     = '0;
        y_in     = '0;
        color_in = '0;
        model_clear();

        // Reset values
        #1;
        check_all("reset");
        @(negedge clk);
        check_all("reset_hold");
        reset = 1'b0;

        // Four channels requesting continuously: strict rotation, 3-cycle spacing
        req = 4'b1111;
        for (int i = 0; i < NCH; i++) begin
            x_in[i*8 +: 8]     = 8'(10 + i);
            y_in[i*7 +: 7]     = 7'(20 + i);
            color_in[i*3 +: 3] = 3'(i + 1);
        end
        for (int t = 1; t <= 13; t++) begin
            tick("rr_all");
            if (plot === 1'b1) begin
                plot_at.push_back(t);
                ack_seq.push_back(ack);
            end
        end
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000;
        exp_seq[4] = 4'b0001;
        chk("rr_all.nplots", 32'(plot_at.size()), 32'd5);
        for (int k = 0; k < 5 && k < ack_seq.size(); k++) begin
            chk("rr_all.order", 32'(ack_seq[k]), 32'(exp_seq[k]));
        end
        for (int k = 1; k < plot_at.size(); k++) begin
            chk("rr_all.spacing", 32'(plot_at[k] - plot_at[k-1]), 32'd3);
        end

        // Single channel 2 with fixed pixel
        req = '0;
        repeat (3) tick("drain");
        req = 4'b0100;
        x_in[16 +: 8]    = 8'd100;
        y_in[14 +: 7]    = 7'd60;
        color_in[6 +: 3] = 3'd5;
        tick("single");
        chk("single.plot", 32'(plot), 32'd1);
        chk("single.ack",  32'(ack), 32'b0100);
        chk("single.x",    32'(x_out), 32'd100);
        chk("single.y",    32'(y_out), 32'd60);
        chk("single.c",    32'(color_out), 32'd5);
        req = '0;
        repeat (3) tick("drain");

        // Busy blocks grants; plot follows right after busy drops
        busy = 1'b1;
        req  = 4'b0010;
        repeat (10) tick("busy_block");
        busy = 1'b0;
        tick("busy_drop");
        chk("busy_drop.plot", 32'(plot), 32'd1);
        chk("busy_drop.ack",  32'(ack), 32'b0010);

        // Busy held 5 cycles after the plot: next grant 2 cycles after it falls
        tick("wait_enter");
        busy = 1'b1;
        repeat (5) tick("wait_busy");
        busy = 1'b0;
        tick("wait_exit");
        chk("wait_exit.plot", 32'(plot), 32'd0);
        tick("wait_regrant");
        chk("wait_regrant.plot", 32'(plot), 32'd1);
        req = '0;
        repeat (3) tick("drain");

        // Reset in the plot cycle clears outputs without waiting for a clock
        req = 4'b1000;
        tick("pre_rst");
        chk("pre_rst.plot", 32'(plot), 32'd1);
        reset = 1'b1;
        #1;
        model_clear();
        check_all("async_rst");
        req = 4'b1010;
        tick("rst_held");
        reset = 1'b0;
        tick("post_rst");
        chk("post_rst.ack", 32'(ack), 32'b0010);
        req = '0;
        repeat (3) tick("drain");

        // Randomised traffic against the model
        for (int t = 0; t < 3000; t++) begin
            req      = 4'($urandom);
            busy     = ($urandom_range(0, 3) == 0);
            x_in     = $urandom;
            y_in     = 28'($urandom);
            color_in = 12'($urandom);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
